// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: condition encodings,
// BHT counter states and the saturating counter update.
package bru_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLTZ = 3'b010,
        BR_BGEZ = 3'b011,
        BR_BGTZ = 3'b100,
        BR_BLEZ = 3'b101,
        BR_BLT  = 3'b110,
        BR_BLTU = 3'b111
    } br_op_e;

    localparam logic [1:0] SNT       = 2'b00;
    localparam logic [1:0] WNT       = 2'b01;
    localparam logic [1:0] WT        = 2'b10;
    localparam logic [1:0] ST        = 2'b11;
    localparam logic [1:0] BHT_RESET = WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != ST)) begin
            nxt = ctr + 2'd1;
        end else if (!taken && (ctr != SNT)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with a combinational
// lookup port and a registered update port, indexed by pc[IDX+1:2].
module bht_2bit
    import bru_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                lookup_taken,
    input  logic                upd_en,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken
);

    localparam int IDX = $clog2(DEPTH);

    logic [1:0]     table_q [DEPTH];
    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;
    logic           unused_pc_bits;

    assign rd_idx = lookup_pc[IDX+1:2];
    assign wr_idx = upd_pc[IDX+1:2];

    assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:IDX+2], lookup_pc[1:0],
                              upd_pc[PC_WIDTH-1:IDX+2], upd_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            table_q[wr_idx] <= sat_update(table_q[wr_idx], upd_taken);
        end
    end

    // Reads the array directly, so a same-index update is seen only next cycle.
    assign lookup_taken = table_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: condition evaluation, mispredict flush/redirect and BHT update.
// Optional counters enabled with `define BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                lookup_taken,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [2:0]          br_op,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0]    br_a,
    input  logic [WIDTH-1:0]    br_b,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                br_pred_taken,
    output logic                res_valid,
    output logic                res_taken,
    output logic                zero,
    output logic                sign,
    output logic                flush,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    logic [WIDTH:0]    udiff;
    logic [WIDTH:0]    sdiff;
    logic              eq;
    logic              ult;
    logic              slt;
    logic              a_neg;
    logic              a_zero;
    logic              taken;
    logic              accept;
    logic              mispredict;
    logic [PC_WIDTH-1:0] next_pc;
    logic              unused_sdiff;

    // Sign-extending to WIDTH+1 bits keeps the signed difference exact, so its MSB is a true less-than.
    assign udiff  = {1'b0, br_a} - {1'b0, br_b};
    assign sdiff  = {br_a[WIDTH-1], br_a} - {br_b[WIDTH-1], br_b};
    assign ult    = udiff[WIDTH];
    assign slt    = sdiff[WIDTH];
    assign eq     = (udiff == '0);
    assign a_neg  = br_a[WIDTH-1];
    assign a_zero = (br_a == '0);
    assign unused_sdiff = ^sdiff[WIDTH-1:0];

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(br_op))
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = ~eq;
            BR_BLTZ: taken = a_neg;
            BR_BGEZ: taken = ~a_neg;
            BR_BGTZ: taken = ~a_neg & ~a_zero;
            BR_BLEZ: taken = a_neg | a_zero;
            BR_BLT:  taken = slt;
            BR_BLTU: taken = ult;
            default: taken = 1'b0;
        endcase
    end

    // A branch arriving while flush is high is on the wrong path and is dropped.
    assign accept     = br_valid & ~stall & ~flush;
    assign mispredict = taken != br_pred_taken;
    assign next_pc    = taken ? br_target : br_pc + PC_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            zero        <= 1'b0;
            sign        <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else if (stall) begin
            flush <= 1'b0;
        end else if (accept) begin
            res_valid   <= 1'b1;
            res_taken   <= taken;
            zero        <= eq;
            sign        <= slt;
            flush       <= mispredict;
            redirect_pc <= next_pc;
        end else begin
            res_valid <= 1'b0;
            flush     <= 1'b0;
        end
    end

    bht_2bit #(
        .DEPTH    (BHT_DEPTH),
        .PC_WIDTH (PC_WIDTH)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken),
        .upd_en       (accept),
        .upd_pc       (br_pc),
        .upd_taken    (taken)
    );

`ifdef BRU_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (accept) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

    assign stat_branches    = branch_cnt;
    assign stat_mispredicts = mispredict_cnt;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch resolution stage for the pipelined CPU; successor to the single-purpose subtract/sign/zero comparator.
- Evaluates eight branch conditions with correct signed and unsigned compares, registers the outcome, and compares it against the fetch-stage prediction.
- On a mispredict, raises a one-cycle flush and a redirect PC.
- Owns a 2-bit saturating branch history table (BHT); the fetch stage reads it for predictions and this block updates it at resolve.

Parameters:
- WIDTH, 32: operand width.
- PC_WIDTH, 32: PC / target width.
- BHT_DEPTH, 64: number of BHT entries; must be a power of 2, minimum 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_pc  in  PC_WIDTH  fetch PC for prediction.
- lookup_taken  out  1  combinational prediction (counter MSB).
- stall  in  1  hold all pipeline registers; ignore br_valid.
- br_valid  in  1  branch present in the resolve stage this cycle.
- br_op  in  3  condition code.
- br_pc  in  PC_WIDTH  PC of the branch.
- br_a  in  WIDTH  rs operand.
- br_b  in  WIDTH  rt operand.
- br_target  in  PC_WIDTH  taken target.
- br_pred_taken  in  1  prediction made at fetch.
- res_valid  out  1  registered: resolution available.
- res_taken  out  1  registered outcome.
- zero  out  1  registered (br_a == br_b).
- sign  out  1  registered signed (br_a < br_b).
- flush  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  PC_WIDTH  registered correct next PC.
- stat_branches  out  32  resolved-branch count (see Optional Feature).
- stat_mispredicts  out  32  mispredict count (see Optional Feature).

Behaviour:
- Reset: every registered output is 0. All BHT entries reset to 2'b01 (weakly not taken).
- br_op encoding:
  - 000 BEQ: a == b.
  - 001 BNE: a != b.
  - 010 BLTZ: a < 0.
  - 011 BGEZ: a >= 0.
  - 100 BGTZ: a > 0.
  - 101 BLEZ: a <= 0.
  - 110 BLT: signed a < b.
  - 111 BLTU: unsigned a < b.
- Compare arithmetic: subtraction is done in WIDTH+1 bits. The signed less-than result must be correct on overflow; taking the raw difference MSB is not acceptable.
- Latency: an accepted branch in cycle N shows its outputs in cycle N+1.
- Accept condition: br_valid & ~stall & ~flush.
- Mispredict = res_taken != br_pred_taken.
  - On mispredict: flush=1 for exactly one cycle.
  - redirect_pc = taken ? br_target : br_pc + 4, computed modulo 2^PC_WIDTH.
  - When there is no mispredict, redirect_pc still carries the correct next PC but flush=0.
- Output hold:
  - When stall=1, all outputs hold their values, except flush, which is forced to 0 after one cycle.
  - A flush is never repeated because of a stall.
- Non-accept cycle (no stall): res_valid=0, flush=0; other outputs hold.
- Wrong-path kill: a br_valid arriving in the same cycle flush=1 is killed. It gets no resolution and no BHT update.
- BHT index = pc[IDX+1:2], where IDX = log2(BHT_DEPTH). The same index function is used for lookup and update.
- BHT update: on accept, the indexed counter increments if taken, decrements if not. It saturates at 00 and 11.
- BHT read/write collision: if lookup and update hit the same index in the same cycle, lookup returns the pre-update value.
- Reset mid-operation: reset clears all registered state and the BHT immediately. Any pending flush is dropped.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - stat_branches increments on every accept.
  - stat_mispredicts increments on every accept that mispredicts.
  - Both counters are 32 bits, saturate at 32'hFFFFFFFF, reset to 0, and update in the same edge as res_valid.
- Undefined: both ports are present and tied to 0; no counter flops are synthesised.

Decomposition:
- Package bru_pkg holds:
  - Op encodings BR_BEQ..BR_BLTU.
  - BHT counter constants: SNT=00, WNT=01, WT=10, ST=11.
  - BHT_RESET = WNT.
- Sub-module bht_2bit (parameters DEPTH, PC_WIDTH) holds:
  - Counter array.
  - Combinational lookup port.
  - Saturating update port.
  - Async reset.

Test Plan:
- BLT, a=32'h7FFFFFFF, b=32'h80000000, pred=1 -> res_taken=0, sign=0, flush=1, redirect_pc=br_pc+4 (overflow case).
- BEQ, a=b=5, br_pc=0x100, target=0x200, pred=0 -> next cycle res_taken=1, zero=1, flush=1 for one cycle, redirect_pc=0x200.
- Four taken branches at pc=0x40 from reset -> lookup_taken at 0x40 goes 0,1,1,1; counter saturates at 11. Then three not-taken -> counter reads 00 and stays there.
- br_valid with stall=1 for 3 cycles -> no res_valid, BHT unchanged. Release stall -> resolves in the next cycle.
- Mispredict in cycle N plus a new br_valid in cycle N+1 -> second branch killed: res_valid=0, BHT entry unchanged. With BRU_STATS_EN: counts 1/1.
- Assert rst while flush=1 -> all outputs 0 immediately, lookup_taken=0 for every PC.
